// File: rtl/line_mem_arbiter_pkg.sv
// Shared arbiter types and the line geometry used by the L1 caches,
// the arbiter and the cacheline adaptor.
package arb_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    localparam int ARB_ADDR_W   = 32;
    localparam int ARB_LINE_W   = 256;
    localparam int ARB_OFFSET_W = 5;

endpackage

// File: rtl/line_mem_arbiter_if.sv
// Cache-side and memory-side bus of the line arbiter.
// slave  : the arbiter's view (serves the caches, drives the memory port).
// master : the environment's view (caches and downstream adaptor).
interface line_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_resp, i_rdata, d_resp, d_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_resp, i_rdata, d_resp, d_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/line_mem_arbiter.sv
// Shares one physical memory port between the I-cache (read-only) and the
// D-cache (read/write). Data side has priority, bounded by a starve counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; requests sampled here (one turnaround cycle)
// SERVE_I | I-cache line read in flight, waiting for pmem_resp
// SERVE_D | D-cache line read or write-back in flight, waiting for pmem_resp
module line_mem_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int LINE_W       = ARB_LINE_W,
    parameter int OFFSET_W     = ARB_OFFSET_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    line_mem_arbiter_if.slave     bus,
    output logic                  busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              starved;
    logic              d_req;
    logic              enter_i;
    logic              enter_d;

    logic              cap_read;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [LINE_W-1:0] cap_wdata;

    assign d_req   = bus.d_read | bus.d_write;
    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Grant decision in IDLE and completion detection in the SERVE states.
    // The trailing D-only branch keeps D from deadlocking if the I side
    // withdraws while the counter sits at its limit.
    always_comb begin
        state_nxt = state;
        enter_i   = 1'b0;
        enter_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !starved) begin
                    enter_d = 1'b1;
                end else if (bus.i_read) begin
                    enter_i = 1'b1;
                end else if (d_req) begin
                    enter_d = 1'b1;
                end
                if (enter_d) begin
                    state_nxt = SERVE_D;
                end else if (enter_i) begin
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Anti-starvation counter: counts D grants taken while I waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (enter_i) begin
            starve_cnt <= '0;
        end else if (enter_d && bus.i_read && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Capture the granted request so the requester may change its inputs
    // after grant; strobes drop on the edge that completes the transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (enter_i) begin
            cap_read  <= 1'b1;
            cap_write <= 1'b0;
            cap_addr  <= bus.i_addr;
            cap_wdata <= '0;
        end else if (enter_d) begin
            // Write wins if both D strobes are (illegally) high.
            cap_read  <= bus.d_read & ~bus.d_write;
            cap_write <= bus.d_write;
            cap_addr  <= bus.d_addr;
            cap_wdata <= bus.d_write ? bus.d_wdata : '0;
        end else if ((state != IDLE) && bus.pmem_resp) begin
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
        end
    end

    assign bus.pmem_read    = cap_read;
    assign bus.pmem_write   = cap_write;
    assign bus.pmem_address = {cap_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign bus.pmem_wdata   = cap_wdata;

    assign bus.i_resp  = (state == SERVE_I) & bus.pmem_resp;
    assign bus.d_resp  = (state == SERVE_D) & bus.pmem_resp;
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;

    assign busy = (state != IDLE);

    // D-cache must never raise read and write together.
    a_d_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.d_read && bus.d_write));

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Self-checking bench for line_mem_arbiter: scoreboard of expected grants.
module tb_line_mem_arbiter;
    import arb_types::*;

    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int LIM = 4;

    localparam logic [LW-1:0] PAT_A = {8{32'hA5A5_1234}};
    localparam logic [LW-1:0] PAT_B = {8{32'hB00B_CAFE}};
    localparam logic [LW-1:0] PAT_C = {4{64'h0123_4567_89AB_CDEF}};

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    line_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    line_mem_arbiter #(
        .ADDR_W(AW), .LINE_W(LW), .OFFSET_W(5), .STARVE_LIMIT(LIM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    task automatic idle_inputs;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, busy} !== 5'b0)
            begin errors++; $display("FAIL reset_strobes got %b want 00000",
                {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, busy}); end
        checks++;
        if (bus.pmem_address !== '0 || bus.pmem_wdata !== '0)
            begin errors++; $display("FAIL reset_bus got addr %h wdata %h want 0",
                bus.pmem_address, bus.pmem_wdata); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy %b want 0", busy); end
    endtask

    task automatic test_i_read;
        txn_t t;
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_1234;
        push_txn(1'b1, 1'b0, 32'h0000_1220, '0);
        tick();
        t = exp_q.pop_front();
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.pmem_address} !== {t.rd, t.wr, t.addr})
            begin errors++; $display("FAIL i_read_grant got %b%b %h want %b%b %h",
                bus.pmem_read, bus.pmem_write, bus.pmem_address, t.rd, t.wr, t.addr); end
        bus.pmem_rdata = PAT_A; bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if ({bus.i_resp, bus.d_resp} !== 2'b10 || bus.i_rdata !== PAT_A)
            begin errors++; $display("FAIL i_read_resp got %b%b %h want 10 %h",
                bus.i_resp, bus.d_resp, bus.i_rdata, PAT_A); end
        tick();
        bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
        #1;
        checks++;
        if ({bus.pmem_read, busy, bus.i_resp} !== 3'b000)
            begin errors++; $display("FAIL i_read_done got rd %b busy %b resp %b want 000",
                bus.pmem_read, busy, bus.i_resp); end
    endtask

    task automatic test_d_write;
        txn_t t;
        bus.d_write = 1'b1; bus.d_addr = 32'h8000_00FF; bus.d_wdata = PAT_B;
        push_txn(1'b0, 1'b1, 32'h8000_00E0, PAT_B);
        tick();
        t = exp_q.pop_front();
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata}
                !== {t.rd, t.wr, t.addr, t.wdata})
            begin errors++; $display("FAIL d_write_grant got %b%b %h %h want %b%b %h %h",
                bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata,
                t.rd, t.wr, t.addr, t.wdata); end
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if ({bus.i_resp, bus.d_resp} !== 2'b01)
            begin errors++; $display("FAIL d_write_resp got %b%b want 01", bus.i_resp, bus.d_resp); end
        tick();
        bus.pmem_resp = 1'b0; bus.d_write = 1'b0;
        #1;
        checks++;
        if ({bus.pmem_write, busy} !== 2'b00)
            begin errors++; $display("FAIL d_write_done got wr %b busy %b want 00",
                bus.pmem_write, busy); end
    endtask

    task automatic test_starvation;
        txn_t t;
        int   waited;
        logic is_i;
        do_reset();
        bus.i_addr = 32'h0000_1000; bus.d_addr = 32'h0000_2000;
        for (int k = 0; k < LIM; k++) push_txn(1'b1, 1'b0, 32'h0000_2000, '0);
        push_txn(1'b1, 1'b0, 32'h0000_1000, '0);
        bus.i_read = 1'b1; bus.d_read = 1'b1;
        for (int g = 0; g <= LIM; g++) begin
            waited = 0;
            while (!busy && waited < 10) begin tick(); waited++; end
            checks++;
            if (waited !== 1)
                begin errors++; $display("FAIL starve_gap grant %0d waited %0d want 1", g, waited); end
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL starve_queue grant %0d queue empty want entry", g);
                break;
            end
            t = exp_q.pop_front();
            is_i = (t.addr == 32'h0000_1000);
            checks++;
            if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata}
                    !== {t.rd, t.wr, t.addr, t.wdata})
                begin errors++; $display("FAIL starve_grant %0d got %b%b %h want %b%b %h",
                    g, bus.pmem_read, bus.pmem_write, bus.pmem_address, t.rd, t.wr, t.addr); end
            if (g == LIM - 1) begin
                checks++;
                if (int'(dut.starve_cnt) !== LIM)
                    begin errors++; $display("FAIL starve_cnt_full got %0d want %0d",
                        dut.starve_cnt, LIM); end
            end
            bus.pmem_rdata = PAT_C ^ LW'(g); bus.pmem_resp = 1'b1;
            #1;
            checks++;
            if ({bus.i_resp, bus.d_resp} !== (is_i ? 2'b10 : 2'b01) ||
                (is_i ? bus.i_rdata : bus.d_rdata) !== (PAT_C ^ LW'(g)))
                begin errors++; $display("FAIL starve_resp %0d got %b%b want %b", g,
                    bus.i_resp, bus.d_resp, (is_i ? 2'b10 : 2'b01)); end
            tick();
            bus.pmem_resp = 1'b0;
            if (is_i) bus.i_read = 1'b0;
        end
        checks++;
        if (int'(dut.starve_cnt) !== 0)
            begin errors++; $display("FAIL starve_cnt_clear got %0d want 0", dut.starve_cnt); end
        // The D side is still requesting in this IDLE cycle; withdraw it first.
        bus.d_read = 1'b0;
        do_reset();
    endtask

    task automatic test_resp_in_idle;
        idle_inputs();
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if ({bus.i_resp, bus.d_resp} !== 2'b00)
            begin errors++; $display("FAIL idle_resp got %b%b want 00", bus.i_resp, bus.d_resp); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_resp_state busy %b want 0", busy); end
        bus.pmem_resp = 1'b0;
    endtask

    task automatic test_reset_mid;
        txn_t t;
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_3004;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_4008;
        push_txn(1'b1, 1'b0, 32'h0000_4000, '0);
        tick();
        t = exp_q.pop_front();
        checks++;
        if ({bus.pmem_read, bus.pmem_address} !== {t.rd, t.addr})
            begin errors++; $display("FAIL rstmid_grant got %b %h want %b %h",
                bus.pmem_read, bus.pmem_address, t.rd, t.addr); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, busy} !== 5'b0 ||
            bus.pmem_address !== '0 || bus.pmem_wdata !== '0)
            begin errors++; $display("FAIL rstmid_clear got %b%b%b%b%b %h want zeros",
                bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp, busy, bus.pmem_address); end
        bus.d_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_txn(1'b1, 1'b0, 32'h0000_3000, '0);
        tick();
        t = exp_q.pop_front();
        checks++;
        if ({bus.pmem_read, bus.pmem_address, busy} !== {t.rd, t.addr, 1'b1})
            begin errors++; $display("FAIL rstmid_regrant got %b %h busy %b want %b %h 1",
                bus.pmem_read, bus.pmem_address, busy, t.rd, t.addr); end
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if (bus.i_resp !== 1'b1) begin errors++; $display("FAIL rstmid_resp got %b want 1", bus.i_resp); end
        tick();
        bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
        tick();
    endtask

    task automatic test_stall;
        txn_t t;
        int   bad;
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_ABCD;
        push_txn(1'b1, 1'b0, 32'h0000_ABC0, '0);
        tick();
        t = exp_q.pop_front();
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            bus.i_addr = $urandom;
            checks++;
            if (bus.pmem_read !== t.rd || bus.pmem_address !== t.addr || busy !== 1'b1 ||
                bus.i_resp !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got rd %b addr %h busy %b want 1 %h 1",
                    c, bus.pmem_read, bus.pmem_address, busy, t.addr);
            end
            tick();
        end
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if (bus.i_resp !== 1'b1) begin errors++; $display("FAIL stall_resp got %b want 1", bus.i_resp); end
        tick();
        bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
        #1;
        checks++;
        if ({bus.pmem_read, busy} !== 2'b00)
            begin errors++; $display("FAIL stall_done got %b%b want 00", bus.pmem_read, busy); end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_starvation();
        test_resp_in_idle();
        test_reset_mid();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

- Shares the single physical memory port between the instruction cache (read-only) and the data cache (read/write).
- Both sides issue whole cache-line requests, including misses and write-backs driven by the decoded `mem_read`/`mem_write` control bits.
- Sits between the two L1 caches and the cacheline adaptor.
- Grants one requester at a time through a registered three-state FSM, with data-side priority bounded by an anti-starvation counter.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `LINE_W`, 256, cache line width in bits
- `OFFSET_W`, 5, line offset bits forced to zero on the memory address
- `STARVE_LIMIT`, 4, consecutive D grants allowed while I is waiting

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_read` in 1: I-cache line read request, level-held until `i_resp`.
- `i_addr` in ADDR_W: I-cache request address.
- `i_resp` out 1: one-cycle completion pulse to the I-cache.
- `i_rdata` out LINE_W: line returned to the I-cache.
- `d_read`, `d_write` in 1 each: D-cache requests, mutually exclusive, level-held until `d_resp`.
- `d_addr` in ADDR_W: D-cache request address.
- `d_wdata` in LINE_W: D-cache write-back line.
- `d_resp` out 1: one-cycle completion pulse to the D-cache.
- `d_rdata` out LINE_W: line returned to the D-cache.
- `pmem_read`, `pmem_write` out 1 each: downstream request strobes.
- `pmem_address` out ADDR_W: downstream line address.
- `pmem_wdata` out LINE_W: downstream write data.
- `pmem_rdata` in LINE_W: downstream read data.
- `pmem_resp` in 1: downstream completion pulse.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- Transitions out of IDLE:
  - `d_req = d_read | d_write` high and starve count < STARVE_LIMIT -> SERVE_D.
  - Else `i_read` high -> SERVE_I.
  - Else stay in IDLE.
- Transitions out of a SERVE state: SERVE_x -> IDLE on the cycle `pmem_resp` is sampled high. Otherwise the state holds indefinitely; there is no timeout.
- Anti-starvation counter, 0..STARVE_LIMIT:
  - Increments on entry to SERVE_D while `i_read` is high; saturates at STARVE_LIMIT.
  - Clears on entry to SERVE_I.
  - Holds otherwise.
  - When it equals STARVE_LIMIT and both sides request, I wins.
- The request type and address are captured into registers on entry to a SERVE state. `pmem_*` outputs are driven from these registers.
- `pmem_address = {captured_addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}`.
- `pmem_wdata` is captured from `d_wdata` on SERVE_D entry with `d_write`; it is 0 otherwise.
- `pmem_read`/`pmem_write` stay high for the whole SERVE state and drop in the IDLE cycle after `pmem_resp`.
- Response routing is combinational:
  - `i_resp = (state==SERVE_I) & pmem_resp`.
  - `d_resp = (state==SERVE_D) & pmem_resp`.
  - `i_rdata` and `d_rdata` are both driven by `pmem_rdata` directly; the selected resp pulse qualifies them.
- Requester contract: deassert the request in the cycle after its resp. A request still high in IDLE is treated as a new request.
- `d_read` and `d_write` both high is illegal. If it occurs, write takes precedence and an assertion fires in simulation.

## Timing
- Reset values, asserted asynchronously: state IDLE, starve counter 0, captured registers 0. All outputs are 0: `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `i_resp`, `d_resp`, `busy`.
- Grant latency: request sampled in IDLE at edge t -> `pmem_*` asserted from t+1.
- Completion: `pmem_resp` in cycle c -> `x_resp` in cycle c (zero latency), state IDLE at c+1, next grant visible at c+2 at the earliest.
- Minimum turnaround between back-to-back transactions: one IDLE cycle.
- `pmem_resp` while in IDLE is ignored: no resp is forwarded and no state change occurs.
- Reset mid-transaction: the in-flight transaction is abandoned and no resp is forwarded. The downstream side is reset by the same `rst_n`.
- The requester address may change after grant without effect, because the address is captured.

## Structure
- Shared package `arb_types`:
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D}.
  - Line-width and offset constants, reused by the caches and the adaptor.
- Single module, no sub-module; the starve counter and capture registers are inline.

## Test plan
- I-only read of 0x0000_1234: `pmem_read` and `pmem_address` = 0x0000_1220 from t+1. With `pmem_resp` and `pmem_rdata` = pattern A, `i_resp` pulses once with `i_rdata` = A, and `d_resp` stays 0.
- D write to 0x8000_00FF with data B: `pmem_write` = 1, `pmem_address` = 0x8000_00E0, `pmem_wdata` = B. `d_resp` coincides with `pmem_resp`, and `pmem_write` is 0 the next cycle.
- Simultaneous `i_read` and `d_read` with STARVE_LIMIT = 4, both held continuously:
  - The first four grants go to D, the fifth goes to I, and the counter reads 0 after it.
  - Each grant is separated by one IDLE cycle.
- `pmem_resp` asserted in IDLE: no `i_resp`/`d_resp` and the state stays IDLE.
- `rst_n` low mid SERVE_D (`pmem_resp` not yet seen): all outputs go to 0 immediately. After release, a pending `i_read` is granted one cycle later.
- Downstream stalls 50 cycles: `pmem_read` and `pmem_address` are stable for all 50 cycles, and `busy` stays 1 throughout.
